// File: rtl/result_collector.sv
// result_collector: gathers two result values per child core, one capture per round,
// and reports round progress, overrun and (optionally) the best result seen.
//
// Parameters:
//   NUM_CORES  number of child-core result channels (2..64)
//   DATA_W     width of each result value
//   IDX_W      core-index width, at least clog2(NUM_CORES)
//
// Ports:
//   Clk          single clock, rising edge
//   Reset        asynchronous active-low reset
//   core_flag    per-core "result ready" level
//   core_val_1   packed first result, core i at [i*DATA_W +: DATA_W]
//   core_val_2   packed second result, same packing
//   clear        re-arms all channels for a new round
//   rd_addr      read index
//   rd_val_1/2   registered slot contents at rd_addr (zero when out of range)
//   done_mask    per-core captured-this-round bits
//   all_done     every done_mask bit set
//   state        0 EMPTY, 1 COLLECT, 2 COMPLETE
//   round_cycles cycles from first capture to completion (saturating)
//   overrun      sticky: a done core raised a new flag edge
//   best_val/best_idx/best_valid  minimum val_1 this round
//
// Build option: define RESULT_COLLECTOR_BEST_EN to enable minimum tracking;
// otherwise the best_* outputs are constant zero.

module result_collector #(
    parameter int NUM_CORES = 31,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = 5
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [NUM_CORES-1:0]        core_flag,
    input  logic [NUM_CORES*DATA_W-1:0] core_val_1,
    input  logic [NUM_CORES*DATA_W-1:0] core_val_2,
    input  logic                        clear,
    input  logic [IDX_W-1:0]            rd_addr,
    output logic [DATA_W-1:0]           rd_val_1,
    output logic [DATA_W-1:0]           rd_val_2,
    output logic [NUM_CORES-1:0]        done_mask,
    output logic                        all_done,
    output logic [1:0]                  state,
    output logic [15:0]                 round_cycles,
    output logic                        overrun,
    output logic [DATA_W-1:0]           best_val,
    output logic [IDX_W-1:0]            best_idx,
    output logic                        best_valid
);

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_COMPLETE = 2'd2
    } state_t;

    logic [NUM_CORES-1:0] flag_q;
    logic [NUM_CORES-1:0] done_q;
    logic                 armed_q;
    logic                 overrun_q;
    state_t               st_q;
    state_t               st_nxt;
    logic [15:0]          cyc_q;

    logic [NUM_CORES-1:0] rise;
    logic [NUM_CORES-1:0] base_mask;
    logic [NUM_CORES-1:0] cap;
    logic [NUM_CORES-1:0] mask_nxt;

    logic [DATA_W-1:0] slot_1 [NUM_CORES];
    logic [DATA_W-1:0] slot_2 [NUM_CORES];
    logic [DATA_W-1:0] rd_1_q;
    logic [DATA_W-1:0] rd_2_q;
    logic [DATA_W-1:0] rd_1_nxt;
    logic [DATA_W-1:0] rd_2_nxt;

    // armed_q stays low for the first edge after reset so a flag that is
    // already high at release is recorded in flag_q instead of captured.
    always_comb begin
        rise      = core_flag & ~flag_q & {NUM_CORES{armed_q}};
        // clear is applied first, so a coincident edge captures into a fresh round
        base_mask = clear ? '0 : done_q;
        cap       = rise & ~base_mask;
        mask_nxt  = base_mask | cap;
        st_nxt    = ST_EMPTY;
        priority case (1'b1)
            (&mask_nxt): st_nxt = ST_COMPLETE;
            (|mask_nxt): st_nxt = ST_COLLECT;
            default:     st_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        rd_1_nxt = '0;
        rd_2_nxt = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (rd_addr == IDX_W'(i)) begin
                rd_1_nxt = slot_1[i];
                rd_2_nxt = slot_2[i];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            flag_q    <= '0;
            armed_q   <= 1'b0;
            done_q    <= '0;
            st_q      <= ST_EMPTY;
            cyc_q     <= '0;
            overrun_q <= 1'b0;
            rd_1_q    <= '0;
            rd_2_q    <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                slot_1[i] <= '0;
                slot_2[i] <= '0;
            end
        end else begin
            flag_q  <= core_flag;
            armed_q <= 1'b1;
            done_q  <= mask_nxt;
            st_q    <= st_nxt;
            rd_1_q  <= rd_1_nxt;
            rd_2_q  <= rd_2_nxt;

            if (clear)
                cyc_q <= '0;
            else if (st_q == ST_COLLECT && cyc_q != 16'hFFFF)
                cyc_q <= cyc_q + 16'd1;

            if (clear)
                overrun_q <= 1'b0;
            else if (|(rise & done_q))
                overrun_q <= 1'b1;

            for (int i = 0; i < NUM_CORES; i++) begin
                if (cap[i]) begin
                    slot_1[i] <= core_val_1[i*DATA_W +: DATA_W];
                    slot_2[i] <= core_val_2[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign rd_val_1     = rd_1_q;
    assign rd_val_2     = rd_2_q;
    assign done_mask    = done_q;
    assign all_done     = &done_q;
    assign state        = st_q;
    assign round_cycles = cyc_q;
    assign overrun      = overrun_q;

`ifdef RESULT_COLLECTOR_BEST_EN
    logic [DATA_W-1:0] bv_q;
    logic [IDX_W-1:0]  bi_q;
    logic              bok_q;
    logic [DATA_W-1:0] bv_nxt;
    logic [IDX_W-1:0]  bi_nxt;
    logic              bok_nxt;
    logic [DATA_W-1:0] cand;

    // Ascending scan: a candidate replaces the current best only when it is
    // strictly smaller, or equal with a lower index, so ties go low.
    always_comb begin
        cand = '0;
        if (clear) begin
            bv_nxt  = '1;
            bi_nxt  = '0;
            bok_nxt = 1'b0;
        end else begin
            bv_nxt  = bv_q;
            bi_nxt  = bi_q;
            bok_nxt = bok_q;
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (cap[i]) begin
                cand = core_val_1[i*DATA_W +: DATA_W];
                if (!bok_nxt || cand < bv_nxt ||
                    (cand == bv_nxt && IDX_W'(i) < bi_nxt)) begin
                    bv_nxt  = cand;
                    bi_nxt  = IDX_W'(i);
                    bok_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            bv_q  <= '1;
            bi_q  <= '0;
            bok_q <= 1'b0;
        end else begin
            bv_q  <= bv_nxt;
            bi_q  <= bi_nxt;
            bok_q <= bok_nxt;
        end
    end

    assign best_val   = bv_q;
    assign best_idx   = bi_q;
    assign best_valid = bok_q;
`else
    assign best_val   = '0;
    assign best_idx   = '0;
    assign best_valid = 1'b0;
`endif

endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: directed scenarios plus randomized traffic for
// result_collector, checked against a round-level reference model.

module tb_result_collector;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int IW = 3;

    logic            Clk = 1'b0;
    logic            Reset = 1'b0;
    logic [N-1:0]    core_flag = '0;
    logic [N*DW-1:0] core_val_1 = '0;
    logic [N*DW-1:0] core_val_2 = '0;
    logic            clear = 1'b0;
    logic [IW-1:0]   rd_addr = '0;
    logic [DW-1:0]   rd_val_1;
    logic [DW-1:0]   rd_val_2;
    logic [N-1:0]    done_mask;
    logic            all_done;
    logic [1:0]      state;
    logic [15:0]     round_cycles;
    logic            overrun;
    logic [DW-1:0]   best_val;
    logic [IW-1:0]   best_idx;
    logic            best_valid;

    result_collector #(.NUM_CORES(N), .DATA_W(DW), .IDX_W(IW)) dut (
        .Clk(Clk), .Reset(Reset), .core_flag(core_flag),
        .core_val_1(core_val_1), .core_val_2(core_val_2),
        .clear(clear), .rd_addr(rd_addr),
        .rd_val_1(rd_val_1), .rd_val_2(rd_val_2),
        .done_mask(done_mask), .all_done(all_done), .state(state),
        .round_cycles(round_cycles), .overrun(overrun),
        .best_val(best_val), .best_idx(best_idx), .best_valid(best_valid)
    );

    always #5 Clk = ~Clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: per-core round bookkeeping, edge-numbered timing.
    bit          m_prev [N];
    bit          m_done [N];
    logic [DW-1:0] m_s1 [N];
    logic [DW-1:0] m_s2 [N];
    bit          m_armed;
    bit          m_ovr;
    bit          m_complete;
    int          m_edge;
    int          m_first;
    int          m_endc;
    logic [DW-1:0] m_rd1;
    logic [DW-1:0] m_rd2;

    function automatic int ndone();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_done[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_prev[i] = 0;
            m_done[i] = 0;
            m_s1[i]   = '0;
            m_s2[i]   = '0;
        end
        m_armed = 0; m_ovr = 0; m_complete = 0;
        m_edge = 0; m_first = 0; m_endc = 0;
        m_rd1 = '0; m_rd2 = '0;
    endtask

    task automatic model_edge();
        bit was_empty;
        int caps;
        if (clear) begin
            for (int i = 0; i < N; i++) m_done[i] = 0;
            m_ovr = 0;
        end
        if (int'(rd_addr) < N) begin
            m_rd1 = m_s1[int'(rd_addr)];
            m_rd2 = m_s2[int'(rd_addr)];
        end else begin
            m_rd1 = '0;
            m_rd2 = '0;
        end
        was_empty = (ndone() == 0);
        caps = 0;
        for (int i = 0; i < N; i++) begin
            if (m_armed && core_flag[i] && !m_prev[i]) begin
                if (m_done[i]) m_ovr = 1;
                else begin
                    m_s1[i] = core_val_1[i*DW +: DW];
                    m_s2[i] = core_val_2[i*DW +: DW];
                    m_done[i] = 1;
                    caps++;
                end
            end
        end
        for (int i = 0; i < N; i++) m_prev[i] = core_flag[i];
        m_armed = 1;
        m_edge++;
        if (was_empty && caps > 0) m_first = m_edge;
        if (ndone() < N) m_complete = 0;
        else if (!m_complete) begin
            m_complete = 1;
            m_endc = m_edge;
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] em;
        int nd, rc;
        logic [DW-1:0] bv;
        logic [IW-1:0] bi;
        logic bok;
        nd = ndone();
        for (int i = 0; i < N; i++) em[i] = m_done[i];
        rc = (nd == 0) ? 0 : ((m_complete ? m_endc : m_edge) - m_first);
        if (rc > 65535) rc = 65535;
        check("done_mask", 64'(done_mask), 64'(em));
        check("all_done", 64'(all_done), 64'(nd == N));
        check("state", 64'(state), (nd == 0) ? 64'd0 : (nd == N) ? 64'd2 : 64'd1);
        check("round_cycles", 64'(round_cycles), 64'(rc));
        check("overrun", 64'(overrun), 64'(m_ovr));
        check("rd_val_1", 64'(rd_val_1), 64'(m_rd1));
        check("rd_val_2", 64'(rd_val_2), 64'(m_rd2));
`ifdef RESULT_COLLECTOR_BEST_EN
        bv = '1; bi = '0; bok = 0;
        for (int i = 0; i < N; i++) begin
            if (m_done[i] && (!bok || m_s1[i] < bv)) begin
                bv = m_s1[i]; bi = IW'(i); bok = 1;
            end
        end
`else
        bv = '0; bi = '0; bok = 0;
`endif
        check("best_val", 64'(best_val), 64'(bv));
        check("best_idx", 64'(best_idx), 64'(bi));
        check("best_valid", 64'(best_valid), 64'(bok));
    endtask

    task automatic tick();
        model_edge();
        @(posedge Clk);
        #1;
        compare_all();
    endtask

    task automatic set_val(input int i, input logic [DW-1:0] v1,
                           input logic [DW-1:0] v2);
        core_val_1[i*DW +: DW] = v1;
        core_val_2[i*DW +: DW] = v2;
    endtask

    task automatic do_clear();
        core_flag = '0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        model_reset();
        // reset state, with all flags already high at release
        core_flag = 4'b1111;
        repeat (2) @(posedge Clk);
        #1;
        compare_all();
        Reset = 1'b1;
        tick();
        tick();
        check("no_capture_at_release", 64'(done_mask), 64'h0);
        core_flag = '0;
        tick();
        core_flag = 4'b0001;
        tick();
        check("capture_after_refall", 64'(done_mask), 64'h1);

        // completion timing
        do_clear();
        core_flag = 4'b0001; tick();
        check("collect_state", 64'(state), 64'd1);
        tick();
        core_flag = 4'b0011; tick(); tick();
        core_flag = 4'b0111; tick(); tick();
        core_flag = 4'b1111; tick();
        check("complete_state", 64'(state), 64'd2);
        check("complete_all_done", 64'(all_done), 64'd1);
        check("complete_cycles", 64'(round_cycles), 64'd6);
        tick();
        check("complete_hold", 64'(round_cycles), 64'd6);

        // readback
        do_clear();
        set_val(2, 16'h1234, 16'hBEEF);
        core_flag = 4'b0100; tick();
        rd_addr = 3'd2; tick();
        check("rd2_val_1", 64'(rd_val_1), 64'h1234);
        check("rd2_val_2", 64'(rd_val_2), 64'hBEEF);
        rd_addr = 3'd7; tick();
        check("rd7_val_1", 64'(rd_val_1), 64'h0);
        check("rd7_val_2", 64'(rd_val_2), 64'h0);

        // overrun
        do_clear();
        set_val(1, 16'h0055, 16'h0066);
        core_flag = 4'b0010; tick();
        core_flag = 4'b0000; tick();
        set_val(1, 16'h0099, 16'h0099);
        core_flag = 4'b0010; tick();
        check("overrun_set", 64'(overrun), 64'd1);
        rd_addr = 3'd1; tick();
        check("overrun_slot_kept", 64'(rd_val_1), 64'h0055);
        tick();
        check("overrun_sticky", 64'(overrun), 64'd1);
        do_clear();
        check("overrun_cleared", 64'(overrun), 64'd0);

        // clear coinciding with a capture
        core_flag = 4'b0000; tick();
        core_flag = 4'b0001; tick();
        tick();
        clear = 1'b1;
        core_flag = 4'b1001;
        tick();
        clear = 1'b0;
        check("clr_cap_mask", 64'(done_mask), 64'h8);
        check("clr_cap_state", 64'(state), 64'd1);
        check("clr_cap_cycles", 64'(round_cycles), 64'd0);

        // best tracking: simultaneous tie, then a smaller value
        do_clear();
        set_val(0, 16'd7, 16'd0);
        set_val(2, 16'd7, 16'd0);
        set_val(1, 16'd3, 16'd0);
        core_flag = 4'b0101; tick();
`ifdef RESULT_COLLECTOR_BEST_EN
        check("best_tie_val", 64'(best_val), 64'd7);
        check("best_tie_idx", 64'(best_idx), 64'd0);
`else
        check("best_off_val", 64'(best_val), 64'd0);
        check("best_off_idx", 64'(best_idx), 64'd0);
`endif
        core_flag = 4'b0111; tick();
`ifdef RESULT_COLLECTOR_BEST_EN
        check("best_new_val", 64'(best_val), 64'd3);
        check("best_new_idx", 64'(best_idx), 64'd1);
`else
        check("best_off_valid", 64'(best_valid), 64'd0);
`endif

        // asynchronous reset mid-round
        do_clear();
        core_flag = 4'b0101; tick();
        check("pre_reset_mask", 64'(done_mask), 64'h5);
        #2;
        Reset = 1'b0;
        #1;
        check("async_rst_mask", 64'(done_mask), 64'h0);
        check("async_rst_state", 64'(state), 64'd0);
        check("async_rst_cycles", 64'(round_cycles), 64'd0);
        model_reset();
        @(posedge Clk);
        #2;
        core_flag = '0;
        Reset = 1'b1;
        tick();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(3) == 0) core_flag[i] = ~core_flag[i];
                set_val(i, DW'($urandom_range(40)), DW'($urandom));
            end
            clear   = ($urandom_range(24) == 0);
            rd_addr = IW'($urandom_range(7));
            tick();
        end
        clear = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 SHALL have parameter NUM_CORES, default 31, number of child-core result channels (2..64).
REQ-002 SHALL have parameter DATA_W, default 32, width of each result value.
REQ-003 SHALL have parameter IDX_W, default 5, core-index width, at least clog2(NUM_CORES).
REQ-004 SHALL have port Clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port core_flag  in  NUM_CORES  per-core "result ready" level from each child.
REQ-007 SHALL have port core_val_1  in  NUM_CORES*DATA_W  packed first result, core i at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port core_val_2  in  NUM_CORES*DATA_W  packed second result, same packing.
REQ-009 SHALL have port clear  in  1  parent pulse that re-arms all channels for a new round.
REQ-010 SHALL have port rd_addr  in  IDX_W  parent read index.
REQ-011 SHALL have port rd_val_1 / rd_val_2  out  DATA_W each  registered slot contents at rd_addr.
REQ-012 SHALL have port done_mask  out  NUM_CORES  per-core captured-this-round bits.
REQ-013 SHALL have port all_done  out  1  high when every done_mask bit is set.
REQ-014 SHALL have port state  out  2  round state: 0 EMPTY, 1 COLLECT, 2 COMPLETE.
REQ-015 SHALL have port round_cycles  out  16  cycles from first capture to completion.
REQ-016 SHALL have port overrun  out  1  sticky; a done core raised a new flag edge.
REQ-017 SHALL have ports best_val  out  DATA_W, best_idx  out  IDX_W, best_valid  out  1  (see Configuration).

Function
REQ-018 SHALL register core_flag each cycle and detect capture events as a 0->1 transition per core.
REQ-019 SHALL, on a capture event for core i with done_mask[i]=0, latch both values into slot i and set done_mask[i] on the same edge; latency flag-rise sample to done bit = 1 cycle.
REQ-020 SHALL ignore a capture event when done_mask[i]=1, leaving slot i unchanged and setting overrun.
REQ-021 SHALL accept any number of simultaneous capture events in one cycle.
REQ-022 SHALL, on clear, zero done_mask and round_cycles, keep slot data, and enter EMPTY.
REQ-023 SHALL, when clear coincides with a capture event, apply the capture after clear: slot latched, done bit set, state COLLECT (or COMPLETE if NUM_CORES events).
REQ-024 SHALL drive all_done combinationally from the done_mask register.
REQ-025 SHALL implement the state transitions EMPTY->COLLECT on first capture; COLLECT->COMPLETE when done_mask becomes all ones; EMPTY->COMPLETE if all cores capture in one cycle; any->EMPTY on clear without capture.
REQ-026 SHALL increment round_cycles every cycle in COLLECT, hold in COMPLETE and EMPTY, and saturate at 16'hFFFF.
REQ-027 SHALL present rd_val_1/rd_val_2 one cycle after rd_addr; rd_addr >= NUM_CORES returns zero.
REQ-028 SHALL keep overrun set until clear or reset.

Reset
REQ-029 SHALL, on Reset low, asynchronously zero all slots, done_mask, registered flags, round_cycles, overrun, rd_val_1, rd_val_2, set state EMPTY, best_val all ones, best_idx 0, best_valid 0.
REQ-030 SHALL treat a flag already high when Reset releases as no capture event until it falls and rises again.

Configuration
REQ-031 SHALL, with macro RESULT_COLLECTOR_BEST_EN defined, track the minimum unsigned val_1 among cores captured this round: best_val, best_idx, best_valid update on the same edge as the done bit; ties, including simultaneous captures, resolve to the lowest index; clear resets to all ones / 0 / 0, then applies any coincident capture.
REQ-032 SHALL, without RESULT_COLLECTOR_BEST_EN, drive best_val, best_idx and best_valid constant zero and contain no comparison logic.

Verification
REQ-033 SHALL cover reset: assert Reset=0 mid-round with done_mask=0x5 -> done_mask=0, state EMPTY, round_cycles=0 immediately, no clock required.
REQ-034 SHALL cover completion: NUM_CORES=4, flags rise on cores 0,1,2,3 at cycles 0,2,4,6 -> state COLLECT from cycle 1, all_done and COMPLETE at cycle 7, round_cycles=6.
REQ-035 SHALL cover readback: core 2 captures val_1=0x1234, val_2=0xBEEF; rd_addr=2 -> rd_val_1=0x1234, rd_val_2=0xBEEF one cycle later; rd_addr=7 -> both 0.
REQ-036 SHALL cover overrun: core 1 flag falls then rises again with new value 0x99 before clear -> slot 1 keeps old value, overrun=1 until clear.
REQ-037 SHALL cover clear and capture in one cycle: clear with core 3 rising -> done_mask=0x8, state COLLECT, round_cycles=0.
REQ-038 SHALL cover the macro: with RESULT_COLLECTOR_BEST_EN, cores 0,2 capture val_1=7 simultaneously, core 1 later val_1=3 -> best 7/idx 0, then 3/idx 1; without the macro all best outputs stay 0.
